// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : CPU front end. Owns the program counter, issues word reads
//                to instruction memory, buffers returned words in a small
//                prefetch FIFO and hands one instruction per cycle to the
//                decoder. Taken branches redirect the PC, flush prefetched
//                and in-flight words, and produce the BL link value.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  output logic [31:0] instruction_set,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        branch_taken,
  input  logic        branch_link,
  input  logic [31:0] branch_pc,
  input  logic [23:0] br_address,
  output logic        link_we,
  output logic [31:0] link_value
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [31:0]       r_pc;
  logic              r_inflight;
  logic              r_discard;
  logic              r_link_we;
  logic [31:0]       r_link_value;

  logic [31:0]       r_fifo_data [FIFO_DEPTH];
  logic [31:0]       r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_occupancy;
  logic              w_room;
  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic [31:0]       w_target;

  // Head of the FIFO drives the decoder; link outputs come straight from registers
  assign instr_valid     = (r_count != '0);
  assign instruction_set = r_fifo_data[r_rd_ptr];
  assign instr_pc        = r_fifo_pc[r_rd_ptr];
  assign imem_addr       = r_pc;
  assign link_we         = r_link_we;
  assign link_value      = r_link_value;

  // Occupancy counts the word already on its way back so the FIFO never overflows
  assign w_occupancy = r_count + {{(CNT_W-1){1'b0}}, r_inflight};
  assign w_pop       = instr_valid && !stall;
  assign w_room      = (w_occupancy < DEPTH_C) || ((w_occupancy == DEPTH_C) && w_pop);
  assign w_accept    = imem_req && imem_ready;
  // Only the response owed to our own request is kept, and only when it is not stale
  assign w_push      = imem_valid && r_inflight && !r_discard && !branch_taken;
  // Branch target: PC of branch + 8 plus the sign-extended word offset
  assign w_target    = branch_pc + 32'd8 + {{6{br_address[23]}}, br_address, 2'b00};

  // Next-state and request decode; a branch always blocks the request that cycle
  always_comb begin
    w_state_next = ST_RESET;
    imem_req     = 1'b0;
    unique case (r_state)
      ST_RESET, ST_FETCH, ST_REDIRECT:
        w_state_next = branch_taken ? ST_REDIRECT : ST_FETCH;
      default:
        w_state_next = ST_RESET;
    endcase
    imem_req = !reset && !branch_taken && w_room;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC, outstanding-request tracking, discard flag and BL link value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_discard    <= 1'b1;
      r_link_we    <= 1'b0;
      r_link_value <= 32'h0;
    end else begin
      r_inflight <= w_accept;
      // Memory answers one cycle after acceptance, so the flag only ever
      // covers the single response slot following a branch
      r_discard  <= branch_taken && r_inflight;
      r_link_we  <= branch_taken && branch_link;
      if (branch_taken && branch_link) begin
        r_link_value <= branch_pc + 32'd4;
      end
      if (branch_taken) begin
        r_pc <= w_target;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  // Prefetch FIFO: branch flush beats push/pop; storage cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= 32'h0;
        r_fifo_pc[i]   <= 32'h0;
      end
    end else if (branch_taken) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= imem_rdata;
        r_fifo_pc[r_wr_ptr]   <= r_pc - 32'd4;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Front end of the CPU pipeline: owns the program counter, issues word reads to instruction memory, buffers returned words in a small prefetch FIFO and presents one instruction per cycle to the instruction decoder (`instruction_set`). Taken branches resolved downstream redirect the PC, flush all prefetched and in-flight words, and produce the BL link value for R14.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `FIFO_DEPTH`, 2: prefetch buffer entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: byte address of requested word; always word-aligned.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_valid` in 1: response valid. Asserted exactly one cycle after each accepted request.
- `imem_rdata` in 32: response word.
- `stall` in 1: decoder cannot take an instruction this cycle.
- `instruction_set` out 32: instruction to decoder, head of FIFO.
- `instr_pc` out 32: address of `instruction_set`.
- `instr_valid` out 1: head entry valid.
- `branch_taken` in 1: taken branch resolved this cycle; single-cycle pulse.
- `branch_link` in 1: branch is BL; qualified by `branch_taken`.
- `branch_pc` in 32: address of the branch instruction.
- `br_address` in 24: signed word offset field of the branch.
- `link_we` out 1: R14 write enable pulse.
- `link_value` out 32: value for R14.

## Operation
- State machine with states RESET, FETCH and REDIRECT.
  - `reset` high: RESET.
  - First cycle with `reset` low: FETCH.
  - `branch_taken` in any non-reset state: REDIRECT for exactly the next cycle, then FETCH.
- PC register `pc`; `imem_addr` = `pc` whenever `imem_req` = 1.
- Request rule in FETCH and REDIRECT: `imem_req` = 1 iff `branch_taken` = 0 and (count + inflight < FIFO_DEPTH, or count + inflight == FIFO_DEPTH and a pop occurs this cycle).
  - count is FIFO occupancy; inflight is 0 or 1.
- Accepted request (`imem_req` & `imem_ready`): `pc` ← `pc` + 4 (wraps mod 2^32); inflight ← 1.
- Response with `imem_valid` = 1:
  - Pushed with its address when the discard flag is clear.
  - Dropped when the discard flag is set; the discard flag then clears.
- Pop: `instr_valid` & !`stall`. Push and pop in the same cycle leave count unchanged.
- Branch (`branch_taken` = 1 in cycle N), highest priority:
  - FIFO cleared.
  - `imem_req` = 0.
  - Discard flag set if a request was accepted in cycle N−1.
  - Any response arriving in cycle N itself is also dropped.
  - `pc` ← `branch_pc` + 8 + (sign-extend(`br_address`) << 2), computed mod 2^32.
- BL: if `branch_link` = 1 with `branch_taken`, then in cycle N+1 `link_we` = 1 for one cycle and `link_value` = `branch_pc` + 4. Otherwise `link_we` = 0 and `link_value` holds its last value.
- `imem_valid` without an outstanding request is ignored. A FIFO push while full cannot occur by construction; the verifier asserts this.

## Timing
- Reset values, effective the cycle after `reset` is sampled high: `pc` = RESET_PC, count = 0, inflight = 0, `instr_valid` = 0, `instruction_set` = 0, `instr_pc` = 0, `imem_req` = 0, `link_we` = 0, `link_value` = 0.
  - The discard flag is set on reset, so a response arriving the cycle after reset is dropped.
- Reset asserted mid-operation: same as power-on reset. No instruction from before reset ever reaches the decoder.
- First request: cycle 0 after reset release, address RESET_PC.
- Latency:
  - Request accepted in cycle K → data arrives in K+1 → `instr_valid` in K+2.
  - Branch in cycle N → target request in N+1 → first target instruction valid in N+3.
- Throughput: 1 instruction/cycle sustained with `stall` = 0 and `imem_ready` = 1.
- Outputs `instruction_set`, `instr_pc` and `instr_valid` hold stable while `stall` = 1.
- `branch_taken` and `stall` in the same cycle: the branch wins and the head is discarded.

## Test plan
- Reset release with RESET_PC = 0, memory returns word = address: requests 0x0, 0x4, 0x8…; `instr_valid` rises in cycle 2; decoder receives 0x0, 0x4, 0x8 on consecutive cycles with `instr_pc` matching.
- `stall` held high for 5 cycles mid-stream: `imem_req` drops once count = 2; head holds 0x8 throughout; on release, 0x8 and 0xC are delivered with no loss or duplication.
- `branch_taken` with `branch_pc` = 0x100, `br_address` = 24'hFFFFFE: in-flight word dropped; next request 0x100; first valid `instr_pc` = 0x100 in N+3; `link_we` stays 0.
- BL with `branch_pc` = 0x20, `br_address` = 24'h000010: target 0x68; `link_we` pulses in N+1 with `link_value` = 0x24.
- `imem_ready` low for 3 cycles, then `reset` asserted while one request is outstanding: the stale response is dropped; after release, first valid `instr_pc` = RESET_PC.
- `branch_taken` coinciding with `stall` = 1 and a full FIFO: FIFO emptied; no old instruction appears afterwards; target fetched per branch timing.
